obstacle_field_renderer: RTL and testbench

//  Parametrised successor to the single-player/single-obstacle game datapath. Owns the player and up to
//  NUM_OBST scrolling obstacles. Runs a per-frame erase/update/draw/collision sequence. Streams one pixel
//  per cycle (x, y, colour, plot) into vga_adapter. Jump/gravity physics, obstacle spawn handshake,

---
 rtl/obstacle_field_pkg.sv | 24 ++
 rtl/rect_scanner.sv | 70 +++++++
 rtl/obstacle_field_renderer.sv | 246 ++++++++++++++++++++++++
 tb/tb_obstacle_field_renderer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_field_pkg.sv
// Shared types and constants for the obstacle field renderer.
//   X_W / Y_W      : pixel coordinate widths (x 8 bits, y 7 bits)
//   *_COLOUR_DEF   : default palette entries
//   state_t        : frame sequencer states
package obstacle_field_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam logic [2:0] BG_COLOUR_DEF     = 3'b000;
  localparam logic [2:0] PLAYER_COLOUR_DEF = 3'b110;
  localparam logic [2:0] OBST_COLOUR_DEF   = 3'b010;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ERASE,
    ST_MOVE,
    ST_DRAW,
    ST_CHECK,
    ST_OVER
  } state_t;

endpackage

// File: rtl/rect_scanner.sv
// Walks a W x H rectangle row-major (x inner), one pixel per cycle.
//   clock, reset  : system clock, synchronous active-high reset
//   start         : load base_x/base_y and begin a scan (also restarts a running scan)
//   base_x/base_y : top-left corner of the rectangle
//   px/py         : current pixel coordinate
//   valid         : px/py hold a pixel of the scan this cycle
//   done          : last pixel of the scan is presented this cycle
// A start asserted together with done chains the next rectangle with no gap.
module rect_scanner #(
  parameter int W  = 4,
  parameter int H  = 4,
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] base_x,
  input  logic [YW-1:0] base_y,
  output logic [XW-1:0] px,
  output logic [YW-1:0] py,
  output logic          valid,
  output logic          done
);

  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int CYW = (H > 1) ? $clog2(H) : 1;

  logic           running;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [XW-1:0]  bx;
  logic [YW-1:0]  by;
  logic           last_x;
  logic           last;

  assign last_x = (cx == CXW'(W - 1));
  assign last   = last_x && (cy == CYW'(H - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      running <= 1'b0;
      cx      <= '0;
      cy      <= '0;
      bx      <= '0;
      by      <= '0;
    end else if (start) begin
      running <= 1'b1;
      cx      <= '0;
      cy      <= '0;
      bx      <= base_x;
      by      <= base_y;
    end else if (running) begin
      if (last) begin
        running <= 1'b0;
      end else if (last_x) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign px    = bx + XW'(cx);
  assign py    = by + YW'(cy);
  assign valid = running;
  assign done  = running && last;

endmodule

// File: rtl/obstacle_field_renderer.sv
// Player plus NUM_OBST scrolling obstacles; per accepted frame_tick runs
// erase -> move -> draw -> collision check, streaming one pixel per cycle.
//   clock, reset              : system clock, synchronous active-high reset
//   frame_tick                : frame pulse, honoured only in IDLE
//   jump                      : level, latched with the accepted frame_tick
//   spawn_valid/spawn_y       : obstacle spawn request and its top row
//   spawn_ready               : one-cycle accept of the spawn request (MOVE)
//   x, y, colour, plot        : registered pixel stream to vga_adapter
//   busy                      : high outside IDLE/OVER
//   score                     : obstacles passed, saturating at 255
//   game_over                 : sticky until reset
module obstacle_field_renderer
  import obstacle_field_pkg::*;
#(
  parameter int         NUM_OBST      = 4,
  parameter int         OBJ_W         = 4,
  parameter int         OBJ_H         = 4,
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120,
  parameter int         PLAYER_X      = 20,
  parameter int         PLAYER_Y0     = 60,
  parameter int         GRAVITY       = 1,
  parameter int         JUMP_STEP     = 3,
  parameter int         OBST_STEP     = 2,
  parameter logic [2:0] BG_COLOUR     = BG_COLOUR_DEF,
  parameter logic [2:0] PLAYER_COLOUR = PLAYER_COLOUR_DEF,
  parameter logic [2:0] OBST_COLOUR   = OBST_COLOUR_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           jump,
  input  logic           spawn_valid,
  input  logic [Y_W-1:0] spawn_y,
  output logic           spawn_ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           busy,
  output logic [7:0]     score,
  output logic           game_over
);

  // Object index: 0 is the player, k is obstacle slot k-1.
  localparam int IW = $clog2(NUM_OBST + 1);
  localparam int SW = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1;

  localparam logic [X_W-1:0] PX      = X_W'(PLAYER_X);
  localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W - OBJ_W);
  localparam logic [X_W-1:0] STEP_X  = X_W'(OBST_STEP);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(SCREEN_H - OBJ_H);
  localparam logic [Y_W-1:0] JUMP_Y  = Y_W'(JUMP_STEP);
  localparam logic [Y_W-1:0] GRAV_Y  = Y_W'(GRAVITY);
  localparam logic [8:0]     PX9     = 9'(PLAYER_X);
  localparam logic [8:0]     OW9     = 9'(OBJ_W);
  localparam logic [7:0]     OH8     = 8'(OBJ_H);

  state_t state, state_n;

  logic [Y_W-1:0]    player_y, py_next;
  logic              jump_l;
  logic [NUM_OBST-1:0] active, act_mv;
  logic [X_W-1:0]    ox [NUM_OBST];
  logic [Y_W-1:0]    oy [NUM_OBST];
  logic [IW-1:0]     obj_idx, obj_idx_n;

  logic              nxt_found;
  logic [IW-1:0]     nxt_idx;
  logic [X_W-1:0]    nxt_x;
  logic [Y_W-1:0]    nxt_y;
  logic              free_found;
  logic [SW-1:0]     free_idx;
  logic [3:0]        pass_cnt;
  logic [8:0]        score_sum;
  logic [7:0]        score_next;
  logic [Y_W-1:0]    spawn_y_c;
  logic              hit;

  logic              obj_start, clr_start;
  logic [X_W-1:0]    obj_bx, obj_px, clr_px;
  logic [Y_W-1:0]    obj_by, obj_py, clr_py;
  logic              obj_valid, obj_done, clr_valid, clr_done;

  rect_scanner #(.W(OBJ_W), .H(OBJ_H), .XW(X_W), .YW(Y_W)) u_obj_scan (
    .clock (clock), .reset (reset), .start (obj_start),
    .base_x(obj_bx), .base_y(obj_by),
    .px    (obj_px), .py   (obj_py), .valid (obj_valid), .done (obj_done)
  );

  rect_scanner #(.W(SCREEN_W), .H(SCREEN_H), .XW(X_W), .YW(Y_W)) u_clr_scan (
    .clock (clock), .reset (reset), .start (clr_start),
    .base_x('0), .base_y('0),
    .px    (clr_px), .py   (clr_py), .valid (clr_valid), .done (clr_done)
  );

  // Datapath helpers: next object to scan, move results, free slot, collision.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    nxt_x     = '0;
    nxt_y     = '0;
    for (int unsigned j = 0; j < NUM_OBST; j++) begin
      if (!nxt_found && active[j] && (IW'(j + 1) > obj_idx)) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(j + 1);
        nxt_x     = ox[j];
        nxt_y     = oy[j];
      end
    end

    if (jump_l) py_next = (player_y >= JUMP_Y) ? player_y - JUMP_Y : '0;
    else        py_next = (player_y >= Y_MAX - GRAV_Y) ? Y_MAX : player_y + GRAV_Y;

    pass_cnt   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned j = 0; j < NUM_OBST; j++) begin
      act_mv[j] = active[j] && (ox[j] >= STEP_X);
      if (active[j] && !act_mv[j]) pass_cnt = pass_cnt + 4'd1;
      if (!free_found && !act_mv[j]) begin
        free_found = 1'b1;
        free_idx   = SW'(j);
      end
    end
    score_sum  = 9'(score) + 9'(pass_cnt);
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
    spawn_y_c  = (spawn_y > Y_MAX) ? Y_MAX : spawn_y;

    hit = (player_y == Y_MAX);
    for (int unsigned j = 0; j < NUM_OBST; j++) begin
      if (active[j] &&
          ({1'b0, ox[j]} + OW9 > PX9) && (PX9 + OW9 > {1'b0, ox[j]}) &&
          ({1'b0, oy[j]} + OH8 > {1'b0, player_y}) &&
          ({1'b0, player_y} + OH8 > {1'b0, oy[j]}))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_n;
  end

  // Scans are chained: the next object's start is issued on the current
  // object's done cycle so pixels stream without bubbles.
  always_comb begin
    state_n     = state;
    obj_start   = 1'b0;
    obj_bx      = PX;
    obj_by      = player_y;
    obj_idx_n   = obj_idx;
    clr_start   = 1'b0;
    spawn_ready = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_start = !clr_valid;
        if (clr_done) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (frame_tick) begin
          state_n   = ST_ERASE;
          obj_start = 1'b1;
          obj_idx_n = '0;
        end
      end
      ST_ERASE, ST_DRAW: begin
        if (obj_done) begin
          if (nxt_found) begin
            obj_start = 1'b1;
            obj_bx    = nxt_x;
            obj_by    = nxt_y;
            obj_idx_n = nxt_idx;
          end else begin
            state_n = (state == ST_ERASE) ? ST_MOVE : ST_CHECK;
          end
        end
      end
      ST_MOVE: begin
        state_n     = ST_DRAW;
        obj_start   = 1'b1;
        obj_by      = py_next;
        obj_idx_n   = '0;
        spawn_ready = spawn_valid && free_found;
      end
      ST_CHECK: state_n = hit ? ST_OVER : ST_IDLE;
      ST_OVER:  state_n = ST_OVER;
      default:  state_n = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      player_y  <= Y_W'(PLAYER_Y0);
      jump_l    <= 1'b0;
      active    <= '0;
      obj_idx   <= '0;
      score     <= '0;
      game_over <= 1'b0;
      for (int unsigned j = 0; j < NUM_OBST; j++) begin
        ox[j] <= '0;
        oy[j] <= '0;
      end
    end else begin
      obj_idx <= obj_idx_n;
      if (state == ST_IDLE && frame_tick) jump_l <= jump;
      if (state == ST_MOVE) begin
        player_y <= py_next;
        score    <= score_next;
        active   <= act_mv;
        for (int unsigned j = 0; j < NUM_OBST; j++) begin
          if (act_mv[j]) ox[j] <= ox[j] - STEP_X;
        end
        if (spawn_ready) begin
          active[free_idx] <= 1'b1;
          ox[free_idx]     <= SPAWN_X;
          oy[free_idx]     <= spawn_y_c;
        end
      end
      if (state == ST_CHECK && hit) game_over <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= BG_COLOUR;
      plot   <= 1'b0;
    end else if (state == ST_CLEAR) begin
      x      <= clr_px;
      y      <= clr_py;
      colour <= BG_COLOUR;
      plot   <= clr_valid;
    end else begin
      x      <= obj_px;
      y      <= obj_py;
      plot   <= obj_valid;
      if (state == ST_DRAW) colour <= (obj_idx == '0) ? PLAYER_COLOUR : OBST_COLOUR;
      else                  colour <= BG_COLOUR;
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_OVER);

endmodule

// File: tb/tb_obstacle_field_renderer.sv
module tb_obstacle_field_renderer;

  localparam int N    = 4;
  localparam int PX   = 20;
  localparam int YMAX = 116;

  logic       clock = 1'b0;
  logic       reset, frame_tick, jump, spawn_valid;
  logic [6:0] spawn_y;
  logic       spawn_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy;
  logic [7:0] score;
  logic       game_over;

  always #5 clock = ~clock;

  obstacle_field_renderer #(.NUM_OBST(N), .PLAYER_X(PX)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .jump(jump),
    .spawn_valid(spawn_valid), .spawn_y(spawn_y), .spawn_ready(spawn_ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .score(score), .game_over(game_over)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: game state and the expected pixel list of one frame.
  int m_py, m_score;
  bit m_over;
  bit m_act[N];
  int m_x[N], m_y[N];
  int exp_q[$];
  int obs_q[$];
  bit seen[19200];

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset();
    m_py = 60; m_score = 0; m_over = 0;
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
  endfunction

  function automatic void add_rect(int bx, int by, int c);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        exp_q.push_back(((bx + dx) << 10) | ((by + dy) << 3) | c);
  endfunction

  function automatic void model_frame(input bit j, input bit sv, input int sy,
                                      output bit exp_ready, output int exp_busy);
    int a_pre, a_post;
    bit hit;
    exp_q.delete();
    a_pre = 0; a_post = 0; hit = 0;
    add_rect(PX, m_py, 0);
    for (int i = 0; i < N; i++) if (m_act[i]) begin add_rect(m_x[i], m_y[i], 0); a_pre++; end
    m_py = j ? ((m_py - 3 < 0) ? 0 : m_py - 3) : ((m_py + 1 > YMAX) ? YMAX : m_py + 1);
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (m_x[i] < 2) begin
          m_act[i] = 0;
          if (m_score < 255) m_score++;
        end else m_x[i] -= 2;
      end
    end
    exp_ready = 0;
    if (sv) begin
      for (int i = 0; i < N; i++) begin
        if (!m_act[i] && !exp_ready) begin
          m_act[i] = 1; m_x[i] = 156; m_y[i] = (sy > YMAX) ? YMAX : sy; exp_ready = 1;
        end
      end
    end
    add_rect(PX, m_py, 6);
    for (int i = 0; i < N; i++) if (m_act[i]) begin add_rect(m_x[i], m_y[i], 2); a_post++; end
    exp_busy = (1 + a_pre) * 16 + (1 + a_post) * 16 + 2;
    for (int i = 0; i < N; i++)
      if (m_act[i] && absi(m_x[i] - PX) < 4 && absi(m_y[i] - m_py) < 4) hit = 1;
    if (m_py == YMAX) hit = 1;
    if (hit) m_over = 1;
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge.
  task automatic run_frame(input bit j, input bit sv, input int sy, output bit er);
    int eb, cyc, nready, k;
    bit inject;
    model_frame(j, sv, sy, er, eb);
    jump = j; spawn_valid = sv; spawn_y = 7'(sy); frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    inject = ($urandom_range(0, 3) == 0);
    obs_q.delete();
    cyc = 0; nready = 0;
    while (busy && cyc < 4000) begin
      if (plot) obs_q.push_back(int'({x, y, colour}));
      if (spawn_ready) nready++;
      cyc++;
      frame_tick = inject && (cyc == 5);
      @(negedge clock);
    end
    if (plot) obs_q.push_back(int'({x, y, colour}));
    frame_tick = 1'b0; spawn_valid = 1'b0;
    check("busy_cycles", cyc, eb);
    check("spawn_ready", nready, int'(er));
    check("pixel_count", obs_q.size(), exp_q.size());
    k = 0;
    while (k < obs_q.size() && k < exp_q.size() && obs_q[k] == exp_q[k]) k++;
    if (k < obs_q.size() && k < exp_q.size()) check("pixel_xyc", obs_q[k], exp_q[k]);
    else if (obs_q.size() > 0) check("pixel_last", obs_q[obs_q.size()-1], exp_q[exp_q.size()-1]);
    check("score", score, m_score);
    check("game_over", game_over, int'(m_over));
  endtask

  task automatic check_clear();
    int cnt, uniq, bad, cyc, idx;
    for (int i = 0; i < 19200; i++) seen[i] = 0;
    cnt = 0; uniq = 0; bad = 0; cyc = 0;
    while (busy && cyc < 25000) begin
      @(negedge clock);
      cyc++;
      if (plot) begin
        cnt++;
        if (colour != 3'd0) bad++;
        idx = int'(y) * 160 + int'(x);
        if (x < 8'd160 && y < 7'd120 && !seen[idx]) begin seen[idx] = 1; uniq++; end
      end
    end
    check("clear_plots", cnt, 19200);
    check("clear_unique", uniq, 19200);
    check("clear_colour", bad, 0);
    check("clear_busy_end", busy, 0);
  endtask

  initial begin : main
    bit er, spawned;
    int jf;
    reset = 1'b1; frame_tick = 1'b0; jump = 1'b0; spawn_valid = 1'b0; spawn_y = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_spawn_ready", spawn_ready, 0);
    check("rst_score", score, 0);
    check("rst_game_over", game_over, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    model_reset();
    check_clear();

    run_frame(0, 0, 0, er);                 // fall 60 -> 61
    for (int i = 0; i < 21; i++) run_frame(1, 0, 0, er);  // climb to 0, clamped
    check("player_top", m_py, 0);

    // Hover near the top while obstacles pass well below the player.
    for (int i = 0; i < 90; i++) begin
      jf = (m_py >= 6);
      run_frame(jf[0], $urandom_range(0, 1) == 1, $urandom_range(20, 127), er);
    end

    // Spawn one obstacle in the player's band and fly on until it hits.
    spawned = 0;
    for (int i = 0; i < 150 && !m_over; i++) begin
      jf = (m_py >= 6);
      run_frame(jf[0], !spawned, m_py, er);
      if (er) spawned = 1;
    end
    check("reached_over", game_over, 1);

    if (m_over) begin
      int np, nb, nr;
      frame_tick = 1'b1; spawn_valid = 1'b1; jump = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      np = 0; nb = 0; nr = 0;
      for (int i = 0; i < 60; i++) begin
        if (plot) np++;
        if (busy) nb++;
        if (spawn_ready) nr++;
        @(negedge clock);
      end
      spawn_valid = 1'b0;
      check("over_plots", np, 0);
      check("over_busy", nb, 0);
      check("over_spawn_ready", nr, 0);
      check("over_sticky", game_over, 1);
      check("over_score", score, m_score);
    end

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("reset2_game_over", game_over, 0);
    model_reset();
    check_clear();

    // Reset while the draw phase is streaming.
    jump = 1'b0; spawn_valid = 1'b0; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    repeat (21) @(negedge clock);
    check("middraw_plot", plot, 1);
    check("middraw_colour", colour, 6);
    reset = 1'b1;
    @(negedge clock);
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 1);
    reset = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!plot && cyc < 10) begin @(negedge clock); cyc++; end
      check("restart_plot", plot, 1);
      check("restart_x", x, 0);
      check("restart_y", y, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
